// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants: register index width, datapath width and
// the number of architectural registers held in the register file.
package arm_pkg;

  localparam int unsigned REG_ADDR_W    = 4;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned NUM_ARCH_REGS = 15;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_rdport.sv
// One register file read port: selects the stored value and busy bit for an
// index and overrides them with any same-cycle writeback to that index.
module regfile_rdport #(
  parameter int unsigned DATA_W   = arm_pkg::DATA_W,
  parameter int unsigned NUM_REGS = arm_pkg::NUM_ARCH_REGS,
  parameter int unsigned ADDR_W   = arm_pkg::REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [NUM_REGS*DATA_W-1:0] regs,
  input  logic [NUM_REGS-1:0]        busy,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_dest,
  input  logic [DATA_W-1:0]          wb_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_busy
);

  logic [DATA_W-1:0] stored;
  logic              stored_busy;
  logic              in_range;
  logic              bypass;

  // Indices beyond NUM_REGS match nothing and read as zero / not busy.
  always_comb begin
    stored      = '0;
    stored_busy = 1'b0;
    in_range    = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        stored      = regs[i*DATA_W +: DATA_W];
        stored_busy = busy[i];
        in_range    = 1'b1;
      end
    end
  end

  assign bypass  = in_range && wb_en && (wb_dest == rd_addr);
  assign rd_data = bypass ? wb_data : stored;
  assign rd_busy = stored_busy & ~bypass;

endmodule

// File: rtl/regfile_sb.sv
// ID-stage register file with write-through forwarding and a one-bit-per-register
// busy scoreboard that feeds the hazard unit.
module regfile_sb #(
  parameter int unsigned DATA_W      = arm_pkg::DATA_W,
  parameter int unsigned NUM_REGS    = arm_pkg::NUM_ARCH_REGS,
  parameter int unsigned ADDR_W      = arm_pkg::REG_ADDR_W,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned RESET_INDEX = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_dest,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush,
  output logic                     busy_any
);

  logic [DATA_W-1:0]          regs_q [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [NUM_REGS-1:0]        busy_q, busy_d;
  logic [NUM_REGS-1:0]        wr_hit, issue_hit;

  // Out-of-range destinations simply produce no hit.
  always_comb begin
    wr_hit    = '0;
    issue_hit = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_hit[i]    = wb_en && (wb_dest == ADDR_W'(i));
      issue_hit[i] = issue_en && (issue_dest == ADDR_W'(i));
    end
  end

  // A new writer issuing alongside a writeback to the same register stays busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (issue_hit[i]) begin
        busy_d[i] = 1'b1;
      end else if (wr_hit[i]) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (RESET_INDEX != 0) ? DATA_W'(i) : '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          regs_q[i] <= wb_data;
        end
      end
      busy_q <= busy_d;
    end
  end

  assign busy_any = |busy_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rdport
    regfile_rdport #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .ADDR_W  (ADDR_W)
    ) u_rdport (
      .rd_addr(rd_addr[p*ADDR_W +: ADDR_W]),
      .regs   (regs_flat),
      .busy   (busy_q),
      .wb_en  (wb_en),
      .wb_dest(wb_dest),
      .wb_data(wb_data),
      .rd_data(rd_data[p*DATA_W +: DATA_W]),
      .rd_busy(rd_busy[p])
    );
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised ARM-pipeline register file with integrated busy scoreboard. It serves the ID stage and replaces the fixed 15×32, two-read-port, negedge-written file. Writes occur on the rising edge with same-cycle write-through forwarding, so a separate half-cycle write is not needed. A per-register busy bit is set when a writing instruction issues and cleared at writeback, giving the hazard unit a direct stall source.

## Interface
- `DATA_W`, default 32: register width.
- `NUM_REGS`, default 15: architectural registers held (R0..R14; PC is external).
- `ADDR_W`, default 4: register index width; must satisfy 2^ADDR_W ≥ NUM_REGS.
- `NUM_RD`, default 2: read port count (1..4).
- `RESET_INDEX`, default 1: 1 → register i resets to i; 0 → all registers reset to 0.

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rd_addr`, in, NUM_RD*ADDR_W: packed read indices; port p is bits [p*ADDR_W +: ADDR_W].
- `rd_data`, out, NUM_RD*DATA_W: packed read data (combinational).
- `rd_busy`, out, NUM_RD: busy bit of each addressed register (combinational).
- `issue_en`, in, 1: an instruction that will write `issue_dest` leaves ID this cycle.
- `issue_dest`, in, ADDR_W: destination index of the issuing instruction.
- `wb_en`, in, 1: writeback valid.
- `wb_dest`, in, ADDR_W: writeback index.
- `wb_data`, in, DATA_W: writeback value.
- `flush`, in, 1: pipeline flush; clears every busy bit.
- `busy_any`, out, 1: OR of all busy bits (registered state, no bypass).

## Operation
- Storage: NUM_REGS × DATA_W registers plus NUM_REGS busy flags.
- Read port p, per cycle:
  - `rd_data[p]` = `wb_data` if `wb_en` and `wb_dest == rd_addr[p]`; otherwise the stored value.
  - Out-of-range index (≥ NUM_REGS) returns 0.
- `rd_busy[p]`:
  - Stored busy bit of `rd_addr[p]`, masked to 0 when a same-cycle writeback to that index is present (the value is already forwarded).
  - An issue in the same cycle does not affect it.
  - Out-of-range index returns 0.
- Write: on the rising edge with `wb_en`, the register at `wb_dest` takes `wb_data`. An out-of-range `wb_dest` is ignored.
- Busy update, evaluated per register at the rising edge, in priority order:
  1. `rst` → 0.
  2. `flush` → 0 for all registers. A same-cycle `issue_en` is discarded; a same-cycle `wb_en` still writes data.
  3. `issue_en` and index == `issue_dest` → 1. This also applies when `wb_dest` equals the same index: the new in-flight writer wins.
  4. `wb_en` and index == `wb_dest` → 0.
  5. Otherwise hold.
- The scoreboard is one bit per register, not a counter. The hazard unit must not issue a second writer to a busy register; doing so is undefined.

## Timing
- Reset (synchronous, one cycle `rst` high):
  - Registers become i (RESET_INDEX=1) or 0.
  - All busy bits become 0.
  - `busy_any` = 0.
  - `rd_data` reflects the reset values in the cycle after the reset edge.
- `rst` has priority over `wb_en`, `issue_en` and `flush` in the same cycle. Reset asserted mid-operation discards any pending writeback.
- Read latency is 0 cycles (combinational from `rd_addr`, `wb_*` and state).
- Write-to-read latency:
  - Same cycle via bypass.
  - From storage on the next cycle.
- Issue-to-busy: the busy bit is visible on `rd_busy` and `busy_any` one cycle after the `issue_en` edge.
- Writeback-to-not-busy: `rd_busy` drops in the same cycle via the mask; `busy_any` drops the next cycle.

## Structure
- Shared package `arm_pkg` holds:
  - `REG_ADDR_W` = 4, `DATA_W` = 32, `NUM_ARCH_REGS` = 15.
  - The `reg_idx_t` typedef.
- One sub-module, `regfile_rdport`: a single read port with bypass mux and busy mask, instantiated NUM_RD times in a generate loop.
- Storage and the busy vector stay in the top level.

## Test plan
- Reset, default parameters: read all indices 0..14 on two ports → `rd_data` = index value; `rd_busy` = 0; `busy_any` = 0. With RESET_INDEX=0 → all reads 0.
- Bypass:
  - Cycle 0: `wb_en`, `wb_dest`=3, `wb_data`=0xDEADBEEF, `rd_addr0`=3 → `rd_data0`=0xDEADBEEF in cycle 0.
  - Cycle 1, `wb_en`=0 → still 0xDEADBEEF.
- Scoreboard:
  - Issue dest 5 → next cycle `rd_busy` for addr 5 = 1, `busy_any` = 1.
  - Writeback 5 with 0x1234 → same-cycle `rd_busy` = 0, `rd_data` = 0x1234.
  - Following cycle → `busy_any` = 0.
- Collision: with R7 busy, apply same-cycle `issue_en` dest 7 and `wb_en` dest 7 (value 0x55) → R7 = 0x55 and R7 still busy next cycle.
- Flush/reset priority:
  - Set R1 and R2 busy, then `flush` with `issue_en` dest 4 → all busy bits 0 next cycle.
  - Separately, `rst` with `wb_en` dest 2 = 0xFF → R2 = 2, not 0xFF.
- Parameters: NUM_RD=4, NUM_REGS=8, ADDR_W=4 → read index 9 returns 0 and not busy; `wb_dest`=9 is ignored with no register changed; four simultaneous reads of distinct registers return the correct values.
